cpu_frame_bridge: RTL and testbench

Display/game-side counterpart of the processor's memory-mapped game registers (rx, ry, var, curScore in; offsetX, offsetY, nextScore out).
- Once per video frame it publishes player inputs and the committed score to the CPU.
- It waits until the CPU's result registers have settled, then commits them atomically to the display.
- The display never sees a half-updated offsetX/offsetY pair.

---
 rtl/game_if_pkg.sv | 28 ++
 rtl/cpu_frame_bridge_if.sv | 40 ++++
 rtl/stability_detector.sv | 44 ++++
 rtl/cpu_frame_bridge.sv | 108 ++++++++++
 tb/tb_cpu_frame_bridge.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_if_pkg.sv
// Shared types for the CPU/display frame bridge.
// Width constants, FSM state encoding, CPU result bundle, score clamp.
package game_if_pkg;

    localparam int COORD_W = 11;
    localparam int SCORE_W = 10;
    localparam int VAR_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] offsetX;
        logic [COORD_W-1:0] offsetY;
        logic [SCORE_W-1:0] nextScore;
    } cpu_regs_t;

    function automatic logic [SCORE_W-1:0] clamp_score(
        input logic [SCORE_W-1:0] s,
        input logic [SCORE_W-1:0] lim
    );
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/cpu_frame_bridge_if.sv
// Signal bundle between video/control side, CPU regfile and display.
// slave: the bridge; master: the surrounding system (or a bench).
interface cpu_frame_bridge_if;
    import game_if_pkg::*;

    logic               frame_start;
    logic [COORD_W-1:0] rx_in;
    logic [COORD_W-1:0] ry_in;
    logic [VAR_W-1:0]   var_in;
    logic [COORD_W-1:0] cpu_offsetX;
    logic [COORD_W-1:0] cpu_offsetY;
    logic [SCORE_W-1:0] cpu_nextScore;

    logic [COORD_W-1:0] rx;
    logic [COORD_W-1:0] ry;
    logic [VAR_W-1:0]   var_sel;
    logic [SCORE_W-1:0] curScore;
    logic [COORD_W-1:0] disp_offsetX;
    logic [COORD_W-1:0] disp_offsetY;
    logic [SCORE_W-1:0] disp_score;
    logic               frame_valid;
    logic               stale;

    modport slave (
        input  frame_start, rx_in, ry_in, var_in,
        input  cpu_offsetX, cpu_offsetY, cpu_nextScore,
        output rx, ry, var_sel, curScore,
        output disp_offsetX, disp_offsetY, disp_score,
        output frame_valid, stale
    );

    modport master (
        output frame_start, rx_in, ry_in, var_in,
        output cpu_offsetX, cpu_offsetY, cpu_nextScore,
        input  rx, ry, var_sel, curScore,
        input  disp_offsetX, disp_offsetY, disp_score,
        input  frame_valid, stale
    );

endinterface

// File: rtl/stability_detector.sv
// Snapshots the CPU result bundle and counts consecutive unchanged cycles.
// Ports: clock/reset, clear (reload, zero count), enable, cur in; snap, stable out.
module stability_detector
    import game_if_pkg::*;
#(
    parameter int STABLE_CYCLES = 8
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      clear,
    input  logic      enable,
    input  cpu_regs_t cur,
    output cpu_regs_t snap,
    output logic      stable
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

    logic [SW-1:0] stab_cnt;
    logic          same;

    assign same   = (cur == snap);
    // Combinational so the commit lands on the edge that sees the last match.
    assign stable = enable && !clear && same && (stab_cnt == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            snap     <= '0;
            stab_cnt <= '0;
        end else if (clear) begin
            snap     <= cur;
            stab_cnt <= '0;
        end else if (enable) begin
            if (!same) begin
                snap     <= cur;
                stab_cnt <= '0;
            end else if (stab_cnt != LAST) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_frame_bridge.sv
// Per-frame publish of player inputs to the CPU and atomic commit of its results.
// Ports: clock, reset (sync, active-high), bus (cpu_frame_bridge_if.slave).
module cpu_frame_bridge
    import game_if_pkg::*;
#(
    parameter int MIN_WAIT      = 16,
    parameter int STABLE_CYCLES = 8,
    parameter int TIMEOUT       = 4096,
    parameter int SCORE_MAX     = 999
) (
    input  logic              clock,
    input  logic              reset,
    cpu_frame_bridge_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SETTLE = SETTLE;
    localparam logic [1:0] ST_HOLD   = HOLD;

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0] MIN_W  = WW'(MIN_WAIT);
    localparam logic [WW-1:0] LAST_W = WW'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

    logic [1:0]         state;
    logic [WW-1:0]      wait_cnt;
    logic [COORD_W-1:0] rx_q, ry_q;
    logic [VAR_W-1:0]   var_q;
    logic [SCORE_W-1:0] cur_score_q;
    logic [COORD_W-1:0] disp_x_q, disp_y_q;
    logic [SCORE_W-1:0] disp_s_q;
    logic               valid_q, stale_q;

    cpu_regs_t cur, snap;
    logic      in_settle, det_clear, commit;

    assign cur       = '{offsetX:   bus.cpu_offsetX,
                         offsetY:   bus.cpu_offsetY,
                         nextScore: bus.cpu_nextScore};
    assign in_settle = (state == ST_SETTLE);
    // Snapshot just follows the CPU until the MIN_WAIT window has elapsed.
    assign det_clear = bus.frame_start || (in_settle && wait_cnt < MIN_W);

    stability_detector #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stab (
        .clock (clock),
        .reset (reset),
        .clear (det_clear),
        .enable(in_settle),
        .cur   (cur),
        .snap  (snap),
        .stable(commit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            var_q       <= '0;
            cur_score_q <= '0;
            disp_x_q    <= '0;
            disp_y_q    <= '0;
            disp_s_q    <= '0;
            valid_q     <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.frame_start) begin
                rx_q        <= bus.rx_in;
                ry_q        <= bus.ry_in;
                var_q       <= bus.var_in;
                cur_score_q <= disp_s_q;
                wait_cnt    <= '0;
                state       <= ST_SETTLE;
                // Overrun: previous frame never committed.
                if (in_settle) stale_q <= 1'b1;
            end else if (in_settle) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (commit) begin
                    disp_x_q    <= snap.offsetX;
                    disp_y_q    <= snap.offsetY;
                    disp_s_q    <= clamp_score(snap.nextScore, SMAX);
                    cur_score_q <= clamp_score(snap.nextScore, SMAX);
                    valid_q     <= 1'b1;
                    stale_q     <= 1'b0;
                    state       <= ST_HOLD;
                end else if (wait_cnt == LAST_W) begin
                    stale_q <= 1'b1;
                    state   <= ST_HOLD;
                end
            end
        end
    end

    assign bus.rx           = rx_q;
    assign bus.ry           = ry_q;
    assign bus.var_sel      = var_q;
    assign bus.curScore     = cur_score_q;
    assign bus.disp_offsetX = disp_x_q;
    assign bus.disp_offsetY = disp_y_q;
    assign bus.disp_score   = disp_s_q;
    assign bus.frame_valid  = valid_q;
    assign bus.stale        = stale_q;

endmodule

// File: tb/tb_cpu_frame_bridge.sv
// Directed bench for cpu_frame_bridge: commit latency, glitch, overrun,
// frame_start on commit edge, timeout, score clamp, reset mid-frame.
module tb_cpu_frame_bridge;
    import game_if_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cpu_frame_bridge_if bus();

    cpu_frame_bridge #(
        .MIN_WAIT     (16),
        .STABLE_CYCLES(8),
        .TIMEOUT      (64),
        .SCORE_MAX    (999)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    int tog_per = 0;
    logic [COORD_W-1:0] exp_ox;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (tog_per != 0 && (cyc % tog_per) == 0)
            bus.cpu_offsetX = bus.cpu_offsetX ^ 11'd1;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.frame_valid && n < budget);
    endtask

    task automatic set_cpu(input int x, input int y, input int s);
        bus.cpu_offsetX   = COORD_W'(x);
        bus.cpu_offsetY   = COORD_W'(y);
        bus.cpu_nextScore = SCORE_W'(s);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.rx, bus.ry, bus.var_sel, bus.curScore} !== '0) begin
            errs++;
            $display("FAIL reset_cpu_side: got %0h want 0",
                     {bus.rx, bus.ry, bus.var_sel, bus.curScore});
        end
        checks++;
        if ({bus.disp_offsetX, bus.disp_offsetY, bus.disp_score,
             bus.frame_valid, bus.stale} !== '0) begin
            errs++;
            $display("FAIL reset_disp_side: got %0h want 0",
                     {bus.disp_offsetX, bus.disp_offsetY, bus.disp_score,
                      bus.frame_valid, bus.stale});
        end
    endtask

    task automatic test_nominal();
        int n;
        bus.rx_in = 11'd100;
        bus.ry_in = 11'd200;
        bus.var_in = 4'd3;
        set_cpu(5, 7, 42);
        pulse_fs();
        checks++;
        if (bus.rx !== 11'd100 || bus.ry !== 11'd200 || bus.var_sel !== 4'd3) begin
            errs++;
            $display("FAIL nominal_publish: got %0d/%0d/%0d want 100/200/3",
                     bus.rx, bus.ry, bus.var_sel);
        end
        wait_valid(60, n);
        checks++;
        if (n !== 24 || bus.frame_valid !== 1'b1) begin
            errs++;
            $display("FAIL nominal_latency: got %0d (valid %0b) want 24", n, bus.frame_valid);
        end
        checks++;
        if (bus.disp_offsetX !== 11'd5 || bus.disp_offsetY !== 11'd7 ||
            bus.disp_score !== 10'd42 || bus.curScore !== 10'd42) begin
            errs++;
            $display("FAIL nominal_commit: got %0d/%0d/%0d cur %0d want 5/7/42 cur 42",
                     bus.disp_offsetX, bus.disp_offsetY, bus.disp_score, bus.curScore);
        end
        checks++;
        if (bus.stale !== 1'b0) begin
            errs++;
            $display("FAIL nominal_stale: got %0b want 0", bus.stale);
        end
        tick();
        checks++;
        if (bus.frame_valid !== 1'b0) begin
            errs++;
            $display("FAIL nominal_pulse_width: got %0b want 0", bus.frame_valid);
        end
    endtask

    task automatic test_glitch();
        int n;
        set_cpu(5, 7, 50);
        pulse_fs();
        n = 0;
        while (n < 60 && !bus.frame_valid) begin
            tick();
            n++;
            if (n == 10) begin
                checks++;
                if (bus.curScore !== 10'd42) begin
                    errs++;
                    $display("FAIL glitch_midframe_cur: got %0d want 42", bus.curScore);
                end
            end
            if (n == 19) bus.cpu_offsetY = 11'd9;
        end
        checks++;
        if (n !== 28) begin
            errs++;
            $display("FAIL glitch_latency: got %0d want 28", n);
        end
        checks++;
        if (bus.disp_offsetY !== 11'd9 || bus.disp_score !== 10'd50 ||
            bus.curScore !== 10'd50) begin
            errs++;
            $display("FAIL glitch_commit: got y %0d s %0d cur %0d want 9/50/50",
                     bus.disp_offsetY, bus.disp_score, bus.curScore);
        end
    endtask

    task automatic test_overrun();
        int n;
        logic saw;
        saw = 1'b0;
        bus.rx_in = 11'd300;
        tog_per = 3;
        pulse_fs();
        for (int i = 0; i < 19; i++) begin
            tick();
            if (bus.frame_valid) saw = 1'b1;
        end
        bus.rx_in = 11'd400;
        pulse_fs();
        tog_per = 0;
        if (bus.frame_valid) saw = 1'b1;
        checks++;
        if (saw !== 1'b0) begin
            errs++;
            $display("FAIL overrun_no_valid: got %0b want 0", saw);
        end
        checks++;
        if (bus.stale !== 1'b1 || bus.rx !== 11'd400) begin
            errs++;
            $display("FAIL overrun_stale_rx: got stale %0b rx %0d want 1/400",
                     bus.stale, bus.rx);
        end
        checks++;
        if (bus.disp_offsetX !== 11'd5 || bus.disp_offsetY !== 11'd9 ||
            bus.disp_score !== 10'd50) begin
            errs++;
            $display("FAIL overrun_disp_kept: got %0d/%0d/%0d want 5/9/50",
                     bus.disp_offsetX, bus.disp_offsetY, bus.disp_score);
        end
        exp_ox = bus.cpu_offsetX;
        wait_valid(60, n);
        checks++;
        if (n !== 24 || bus.stale !== 1'b0 || bus.disp_offsetX !== exp_ox) begin
            errs++;
            $display("FAIL overrun_recover: got n %0d stale %0b x %0d want 24/0/%0d",
                     n, bus.stale, bus.disp_offsetX, exp_ox);
        end
    endtask

    task automatic test_fs_on_commit();
        int n;
        bus.rx_in = 11'd7;
        set_cpu(20, 21, 60);
        pulse_fs();
        for (int i = 0; i < 23; i++) tick();
        bus.rx_in = 11'd8;
        pulse_fs();
        checks++;
        if (bus.frame_valid !== 1'b0 || bus.stale !== 1'b1 || bus.rx !== 11'd8) begin
            errs++;
            $display("FAIL fscommit_flags: got valid %0b stale %0b rx %0d want 0/1/8",
                     bus.frame_valid, bus.stale, bus.rx);
        end
        checks++;
        if (bus.disp_offsetX !== exp_ox || bus.disp_score !== 10'd50 ||
            bus.curScore !== 10'd50) begin
            errs++;
            $display("FAIL fscommit_disp_kept: got x %0d s %0d cur %0d want %0d/50/50",
                     bus.disp_offsetX, bus.disp_score, bus.curScore, exp_ox);
        end
        wait_valid(60, n);
        checks++;
        if (n !== 24 || bus.disp_offsetX !== 11'd20 || bus.disp_offsetY !== 11'd21 ||
            bus.disp_score !== 10'd60 || bus.stale !== 1'b0) begin
            errs++;
            $display("FAIL fscommit_next: got n %0d %0d/%0d/%0d stale %0b want 24 20/21/60 0",
                     n, bus.disp_offsetX, bus.disp_offsetY, bus.disp_score, bus.stale);
        end
    endtask

    task automatic test_timeout();
        logic saw;
        saw = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tog_per = 3;
        pulse_fs();
        for (int n = 1; n <= 64; n++) begin
            tick();
            if (bus.frame_valid) saw = 1'b1;
            if (n == 63) begin
                checks++;
                if (bus.stale !== 1'b0) begin
                    errs++;
                    $display("FAIL timeout_early: got stale %0b want 0", bus.stale);
                end
            end
        end
        checks++;
        if (bus.stale !== 1'b1) begin
            errs++;
            $display("FAIL timeout_stale: got %0b want 1", bus.stale);
        end
        tog_per = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.frame_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || bus.stale !== 1'b1) begin
            errs++;
            $display("FAIL timeout_hold: got valid_seen %0b stale %0b want 0/1", saw, bus.stale);
        end
        checks++;
        if ({bus.disp_offsetX, bus.disp_offsetY, bus.disp_score} !== '0) begin
            errs++;
            $display("FAIL timeout_disp: got %0d/%0d/%0d want 0/0/0",
                     bus.disp_offsetX, bus.disp_offsetY, bus.disp_score);
        end
    endtask

    task automatic test_saturation();
        int n;
        int sc [4]  = '{1010, 999, 1023, 998};
        int exp [4] = '{999, 999, 999, 998};
        for (int i = 0; i < 4; i++) begin
            set_cpu(1, 2, sc[i]);
            pulse_fs();
            wait_valid(60, n);
            checks++;
            if (n !== 24 || bus.disp_score !== SCORE_W'(exp[i]) ||
                bus.curScore !== SCORE_W'(exp[i])) begin
                errs++;
                $display("FAIL sat_%0d: got n %0d disp %0d cur %0d want 24/%0d/%0d",
                         sc[i], n, bus.disp_score, bus.curScore, exp[i], exp[i]);
            end
            if (i == 0) begin
                checks++;
                if (bus.stale !== 1'b0) begin
                    errs++;
                    $display("FAIL sat_stale_clear: got %0b want 0", bus.stale);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic saw;
        saw = 1'b0;
        set_cpu(11, 12, 13);
        pulse_fs();
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.rx, bus.ry, bus.var_sel, bus.curScore, bus.disp_offsetX,
             bus.disp_offsetY, bus.disp_score, bus.frame_valid, bus.stale} !== '0) begin
            errs++;
            $display("FAIL rstmid_outputs: got rx %0d cur %0d disp_s %0d stale %0b want all 0",
                     bus.rx, bus.curScore, bus.disp_score, bus.stale);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.frame_valid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0 || bus.disp_offsetX !== 11'd0) begin
            errs++;
            $display("FAIL rstmid_idle: got valid_seen %0b x %0d want 0/0",
                     saw, bus.disp_offsetX);
        end
        pulse_fs();
        wait_valid(60, n);
        checks++;
        if (n !== 24 || bus.disp_offsetX !== 11'd11 || bus.disp_score !== 10'd13) begin
            errs++;
            $display("FAIL rstmid_restart: got n %0d x %0d s %0d want 24/11/13",
                     n, bus.disp_offsetX, bus.disp_score);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.rx_in = '0;
        bus.ry_in = '0;
        bus.var_in = '0;
        set_cpu(0, 0, 0);
        test_reset();
        for (int i = 0; i < 8; i++) tick();
        test_nominal();
        test_glitch();
        test_overrun();
        test_fs_on_commit();
        test_timeout();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
